// File: rtl/alu_muldiv_seq_if.sv
// Handshake and result bundle for the sequential multiply/divide unit.
// The master side issues operations and the slave side returns status and HI/LO.
interface alu_muldiv_seq_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic [2:0]       Op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Busy;
    logic             Done;
    logic             DivZero;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (
        output Start, Op, A, B,
        input  Busy, Done, DivZero, HI, LO
    );

    modport slave (
        input  Start, Op, A, B,
        output Busy, Done, DivZero, HI, LO
    );
endinterface

// File: rtl/alu_muldiv_seq.sv
// Iterative MIPS-style multiply/divide unit with HI/LO result registers.
// It performs one shift-add or restoring-subtract step per cycle on operand magnitudes and fixes the signs at the end.
module alu_muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    alu_muldiv_seq_if.slave   bus
);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MADD  = 3'b100;
    localparam logic [2:0] OP_MSUB  = 3'b101;
    localparam logic [2:0] OP_MTHI  = 3'b110;

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    state_t r_state;
    state_t w_stateNext;

    logic [2:0]         r_op;
    logic [WIDTH-1:0]   r_magA;
    logic [WIDTH-1:0]   r_magB;
    logic               r_negRes;
    logic               r_negRem;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_work;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_divZero;

    logic               w_accept;
    logic               w_isMove;
    logic               w_isDivIn;
    logic               w_divByZero;
    logic               w_signedIn;
    logic               w_signA;
    logic               w_signB;
    logic [WIDTH-1:0]   w_magA;
    logic [WIDTH-1:0]   w_magB;
    logic               w_lastStep;
    logic               w_busy;
    logic               w_done;

    logic [WIDTH:0]     w_mulSum;
    logic [2*WIDTH-1:0] w_mulNext;
    logic [WIDTH:0]     w_divShift;
    logic [WIDTH-1:0]   w_divSub;
    logic               w_divGe;
    logic [WIDTH-1:0]   w_divRem;
    logic [2*WIDTH-1:0] w_divNext;
    logic [2*WIDTH-1:0] w_workNext;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [2*WIDTH-1:0] w_result;

    // Request decode: only meaningful when a Start is accepted outside RUN.
    assign w_accept    = (r_state != RUN) && bus.Start;
    assign w_isMove    = (bus.Op[2:1] == 2'b11);
    assign w_isDivIn   = (bus.Op[2:1] == 2'b01);
    assign w_divByZero = w_isDivIn && (bus.B == '0);
    assign w_signedIn  = (bus.Op == OP_MULT) || (bus.Op == OP_DIV) ||
                         (bus.Op == OP_MADD) || (bus.Op == OP_MSUB);
    assign w_signA     = w_signedIn & bus.A[WIDTH-1];
    assign w_signB     = w_signedIn & bus.B[WIDTH-1];
    assign w_magA      = w_signA ? -bus.A : bus.A;
    assign w_magB      = w_signB ? -bus.B : bus.B;
    assign w_lastStep  = (r_state == RUN) && (r_cnt == CNT_LAST);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE, FIN: begin
                w_done = (r_state == FIN);
                if (bus.Start) begin
                    w_stateNext = (w_isMove || w_divByZero) ? FIN : RUN;
                end else begin
                    w_stateNext = IDLE;
                end
            end
            RUN: begin
                w_busy = 1'b1;
                if (r_cnt == CNT_LAST) begin
                    w_stateNext = FIN;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    // Multiply keeps {partial product, remaining multiplier}; divide keeps {remainder, dividend/quotient}.
    always_comb begin
        w_mulSum   = {1'b0, r_work[2*WIDTH-1:WIDTH]} + {1'b0, (r_work[0] ? r_magA : '0)};
        w_mulNext  = {w_mulSum, r_work[WIDTH-1:1]};
        w_divShift = r_work[2*WIDTH-1:WIDTH-1];
        w_divGe    = (w_divShift >= {1'b0, r_magB});
        w_divSub   = w_divShift[WIDTH-1:0] - r_magB;
        w_divRem   = w_divGe ? w_divSub : w_divShift[WIDTH-1:0];
        w_divNext  = {w_divRem, r_work[WIDTH-2:0], w_divGe};
        w_workNext = (r_op[2:1] == 2'b01) ? w_divNext : w_mulNext;
        w_prod     = r_negRes ? -w_workNext : w_workNext;
        w_quo      = r_negRes ? -w_workNext[WIDTH-1:0] : w_workNext[WIDTH-1:0];
        w_rem      = r_negRem ? -w_workNext[2*WIDTH-1:WIDTH] : w_workNext[2*WIDTH-1:WIDTH];
        w_result   = {r_hi, r_lo};
        case (r_op)
            OP_MULT, OP_MULTU: w_result = w_prod;
            OP_DIV, OP_DIVU:   w_result = {w_rem, w_quo};
            OP_MADD:           w_result = {r_hi, r_lo} + w_prod;
            OP_MSUB:           w_result = {r_hi, r_lo} - w_prod;
            default:           w_result = {r_hi, r_lo};
        endcase
    end

    // HI/LO move only on a move request, on the final iteration, or on reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_op      <= '0;
            r_magA    <= '0;
            r_magB    <= '0;
            r_negRes  <= 1'b0;
            r_negRem  <= 1'b0;
            r_cnt     <= '0;
            r_work    <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_divZero <= 1'b0;
        end else if (w_accept) begin
            r_divZero <= w_divByZero;
            if (w_isMove) begin
                if (bus.Op == OP_MTHI) begin
                    r_hi <= bus.A;
                end else begin
                    r_lo <= bus.A;
                end
            end else begin
                r_op     <= bus.Op;
                r_magA   <= w_magA;
                r_magB   <= w_magB;
                r_negRes <= w_signA ^ w_signB;
                r_negRem <= w_signA;
                r_cnt    <= '0;
                r_work   <= w_isDivIn ? {{WIDTH{1'b0}}, w_magA} : {{WIDTH{1'b0}}, w_magB};
            end
        end else if (r_state == RUN) begin
            r_cnt  <= r_cnt + CNT_W'(1);
            r_work <= w_workNext;
            if (w_lastStep) begin
                {r_hi, r_lo} <= w_result;
            end
        end
    end

    assign bus.Busy    = w_busy;
    assign bus.Done    = w_done;
    assign bus.DivZero = w_done && r_divZero;
    assign bus.HI      = r_hi;
    assign bus.LO      = r_lo;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Randomized self-checking bench for alu_muldiv_seq against a cycle-count and plain-arithmetic reference model.
// Directed sequences pin the model to hand-computed results before the random phase.
module tb_alu_muldiv_seq;

    localparam int W = 32;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MADD  = 3'b100;
    localparam logic [2:0] OP_MSUB  = 3'b101;
    localparam logic [2:0] OP_MTHI  = 3'b110;
    localparam logic [2:0] OP_MTLO  = 3'b111;

    logic Clk = 1'b0;
    logic Reset = 1'b1;

    always #5 Clk = ~Clk;

    alu_muldiv_seq_if #(.WIDTH(W)) bus ();

    alu_muldiv_seq #(.WIDTH(W)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    int          checks    = 0;
    int          failures  = 0;
    bit          checkEn   = 1'b0;
    int          mBusyLeft = 0;
    bit          mDone     = 1'b0;
    bit          mDz       = 1'b0;
    logic [63:0] mHiLo     = '0;
    logic [63:0] mPending  = '0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Result of an arithmetic op straight from signed/unsigned integer arithmetic.
    function automatic logic [63:0] refResult(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [63:0] hilo);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] ua;
        logic [63:0] ub;
        logic [63:0] res;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        res = hilo;
        case (op)
            OP_MULT:  res = 64'(sa * sb);
            OP_MULTU: res = ua * ub;
            OP_DIV: begin
                q   = sa / sb;
                r   = sa % sb;
                res = {r[31:0], q[31:0]};
            end
            OP_DIVU:  res = {a % b, a / b};
            OP_MADD:  res = hilo + 64'(sa * sb);
            OP_MSUB:  res = hilo - 64'(sa * sb);
            default:  res = hilo;
        endcase
        return res;
    endfunction

    // Reference timing: an accepted arithmetic op stays busy W cycles, then completes for one cycle.
    always @(posedge Clk) begin
        if (Reset) begin
            mBusyLeft = 0;
            mDone     = 1'b0;
            mDz       = 1'b0;
            mHiLo     = '0;
        end else if (mBusyLeft > 0) begin
            mBusyLeft--;
            mDz   = 1'b0;
            mDone = (mBusyLeft == 0);
            if (mBusyLeft == 0) begin
                mHiLo = mPending;
            end
        end else begin
            mDone = 1'b0;
            mDz   = 1'b0;
            if (bus.Start) begin
                if (bus.Op == OP_MTHI) begin
                    mHiLo[63:32] = bus.A;
                    mDone        = 1'b1;
                end else if (bus.Op == OP_MTLO) begin
                    mHiLo[31:0] = bus.A;
                    mDone       = 1'b1;
                end else if ((bus.Op == OP_DIV || bus.Op == OP_DIVU) && bus.B == '0) begin
                    mDone = 1'b1;
                    mDz   = 1'b1;
                end else begin
                    mPending  = refResult(bus.Op, bus.A, bus.B, mHiLo);
                    mBusyLeft = W;
                end
            end
        end
    end

    always @(negedge Clk) begin
        if (checkEn) begin
            checkOutput("busy",    64'(bus.Busy),    64'(mBusyLeft > 0));
            checkOutput("done",    64'(bus.Done),    64'(mDone));
            checkOutput("divZero", 64'(bus.DivZero), 64'(mDone && mDz));
            checkOutput("hi",      64'(bus.HI),      64'(mHiLo[63:32]));
            checkOutput("lo",      64'(bus.LO),      64'(mHiLo[31:0]));
        end
    end

    // Issue one op at a negedge and wait (bounded) for Done; optional mid-run Start glitch or reset pulse.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input int glitchAt, input int resetAt,
                                 output int cycles, output bit sawDone);
        bus.Start = 1'b1;
        bus.Op    = op;
        bus.A     = a;
        bus.B     = b;
        @(negedge Clk);
        bus.Start = 1'b0;
        bus.Op    = 3'($urandom);
        bus.A     = $urandom;
        bus.B     = $urandom;
        cycles    = 1;
        sawDone   = 1'b0;
        while (cycles <= 40) begin
            if (bus.Done) begin
                sawDone = 1'b1;
                break;
            end
            bus.Start = (cycles == glitchAt);
            Reset     = (cycles == resetAt);
            @(negedge Clk);
            cycles++;
        end
        bus.Start = 1'b0;
        Reset     = 1'b0;
        if (!sawDone && resetAt == 0) begin
            checkOutput("doneTimeout", 64'(sawDone), 64'(1));
        end
    endtask

    initial begin
        int          cyc;
        bit          done;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;

        bus.Start = 1'b0;
        bus.Op    = '0;
        bus.A     = '0;
        bus.B     = '0;
        Reset     = 1'b1;
        @(posedge Clk);
        checkEn = 1'b1;
        repeat (2) @(negedge Clk);
        checkOutput("resetBusy", 64'(bus.Busy), 64'(0));
        checkOutput("resetDone", 64'(bus.Done), 64'(0));
        checkOutput("resetHiLo", {bus.HI, bus.LO}, 64'(0));
        Reset = 1'b0;

        // Start on the first edge after reset release.
        applyStimulus(OP_MULT, 32'hFFFFFFFD, 32'd5, 0, 0, cyc, done);
        checkOutput("multLatency", 64'(cyc), 64'(33));
        checkOutput("multNeg", {bus.HI, bus.LO}, 64'hFFFFFFFF_FFFFFFF1);

        applyStimulus(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, cyc, done);
        checkOutput("multuMax", {bus.HI, bus.LO}, 64'hFFFFFFFE_00000001);
        applyStimulus(OP_MULT, 32'h80000000, 32'h80000000, 0, 0, cyc, done);
        checkOutput("multMinMin", {bus.HI, bus.LO}, 64'h40000000_00000000);

        applyStimulus(OP_DIVU, 32'd100, 32'd7, 0, 0, cyc, done);
        checkOutput("divu100by7", {bus.HI, bus.LO}, {32'd2, 32'd14});
        applyStimulus(OP_DIV, 32'hFFFFFFF9, 32'd2, 0, 0, cyc, done);
        checkOutput("divNeg7by2", {bus.HI, bus.LO}, 64'hFFFFFFFF_FFFFFFFD);
        applyStimulus(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 0, 0, cyc, done);
        checkOutput("divOverflow", {bus.HI, bus.LO}, 64'h00000000_80000000);

        applyStimulus(OP_MTLO, 32'h10, 32'h0, 0, 0, cyc, done);
        checkOutput("mtloLatency", 64'(cyc), 64'(1));
        applyStimulus(OP_MTHI, 32'h0, 32'h0, 0, 0, cyc, done);
        applyStimulus(OP_MADD, 32'd2, 32'd3, 0, 0, cyc, done);
        checkOutput("madd", {bus.HI, bus.LO}, 64'h00000000_00000016);
        applyStimulus(OP_MSUB, 32'd4, 32'd8, 0, 0, cyc, done);
        checkOutput("msub", {bus.HI, bus.LO}, 64'hFFFFFFFF_FFFFFFF6);

        applyStimulus(OP_MTHI, 32'hAA, 32'h0, 0, 0, cyc, done);
        applyStimulus(OP_MTLO, 32'hBB, 32'h0, 0, 0, cyc, done);
        bus.Start = 1'b1;
        bus.Op    = OP_DIVU;
        bus.A     = 32'd5;
        bus.B     = 32'd0;
        @(negedge Clk);
        bus.Start = 1'b0;
        checkOutput("divZeroFlag", 64'(bus.DivZero), 64'(1));
        checkOutput("divZeroDone", 64'(bus.Done), 64'(1));
        checkOutput("divZeroHiLo", {bus.HI, bus.LO}, {32'hAA, 32'hBB});
        @(negedge Clk);

        applyStimulus(OP_MULTU, 32'd7, 32'd9, 12, 0, cyc, done);
        checkOutput("glitchIgnored", {bus.HI, bus.LO}, 64'd63);

        applyStimulus(OP_MULTU, 32'd1234, 32'd5678, 0, 10, cyc, done);
        checkOutput("abortNoDone", 64'(done), 64'(0));
        checkOutput("abortHiLo", {bus.HI, bus.LO}, 64'(0));
        applyStimulus(OP_MULTU, 32'd6, 32'd7, 0, 0, cyc, done);
        checkOutput("afterAbort", {bus.HI, bus.LO}, 64'd42);

        for (int i = 0; i < 80; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'h0;
                1:       b = 32'hFFFFFFFF;
                2:       b = 32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            applyStimulus(op, a, b, ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 28)) : 0,
                          0, cyc, done);
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 3)) @(negedge Clk);
            end
        end

        @(negedge Clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation watchdog expired");
    end

endmodule

// File: doc/alu_muldiv_seq.md
ALU_MULDIV_SEQ -- requirements
Module: alu_muldiv_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/HI/LO width; legal values are even integers >= 4.
REQ-002 SHALL have port Clk, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port Reset, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have port Start, input, 1, request; sampled only when not Busy.
REQ-005 SHALL have port Op, input, 3, operation select: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MADD, 101 MSUB, 110 MTHI, 111 MTLO.
REQ-006 SHALL have ports A and B, input, WIDTH each, operands (A = multiplicand/dividend/move source, B = multiplier/divisor).
REQ-007 SHALL have port Busy, output, 1, iterative operation in progress.
REQ-008 SHALL have port Done, output, 1, one-cycle completion pulse.
REQ-009 SHALL have port DivZero, output, 1, valid with Done; divisor was zero.
REQ-010 SHALL have ports HI and LO, output, WIDTH each, architectural result registers.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, FIN; Busy = (state == RUN).
REQ-012 IDLE or FIN with Start=1 and Op in {MULT..MSUB}: SHALL latch Op, operand magnitudes, sign flags; counter=0; go to RUN.
REQ-013 Start=1 while Busy SHALL be ignored; no latch, no state change.
REQ-014 RUN SHALL perform exactly one shift-add (multiply) or one restoring-subtract (divide) step per cycle, counter incremented each cycle.
REQ-015 After WIDTH RUN cycles SHALL go to FIN, write HI/LO on that edge; Done=1 during FIN only; latency Start edge -> Done high = WIDTH+1 cycles.
REQ-016 FIN with no Start SHALL return to IDLE next cycle; FIN with Start SHALL accept it per REQ-012/REQ-018 (back-to-back ops).
REQ-017 Multiply: signed ops SHALL multiply magnitudes then negate 2*WIDTH product if sign(A) xor sign(B); MULT/MULTU write {HI,LO} = product.
REQ-018 MADD/MSUB SHALL write {HI,LO} = {HI,LO} +/- signed product, modulo 2^(2*WIDTH); HI/LO value at Start edge is used.
REQ-019 Divide: LO = quotient, HI = remainder; signed: quotient negated if signs differ, remainder takes dividend sign; results truncated to WIDTH.
REQ-020 DIV of most-negative by -1 SHALL give LO = most-negative, HI = 0 (no trap).
REQ-021 DIV/DIVU with B=0 SHALL skip RUN: go directly to FIN, DivZero=1, HI/LO unchanged; DivZero=0 for all other completions.
REQ-022 MTHI/MTLO with Start in IDLE/FIN SHALL write HI (resp. LO) = A on that edge, other register unchanged, go to FIN (Done one cycle later).
REQ-023 HI/LO SHALL change only at the edges named in REQ-015, REQ-022 and on Reset.
REQ-024 Operand inputs SHALL be don't-care after the Start edge; results depend only on latched values.

Reset
REQ-025 Reset=1 at a rising edge SHALL force state IDLE, counter 0, HI=0, LO=0, Busy=0, Done=0, DivZero=0, overriding Start.
REQ-026 Reset during RUN SHALL abort the operation with no HI/LO write and no Done pulse.
REQ-027 First Start SHALL be accepted on the first edge after Reset deasserts.

Verification (WIDTH=32)
REQ-028 MULT A=0xFFFFFFFD (-3), B=5 -> Busy 32 cycles, Done at cycle 33, HI=0xFFFFFFFF, LO=0xFFFFFFF1.
REQ-029 MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; MULT 0x80000000*0x80000000 -> HI=0x40000000, LO=0.
REQ-030 DIVU 100/7 -> LO=14, HI=2; DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-031 MTLO A=0x10, MTHI A=0, then MADD 2*3 -> LO=0x16, HI=0; then MSUB 4*8 -> HI=0xFFFFFFFF, LO=0xFFFFFFF6.
REQ-032 DIVU 5/0 with HI=0xAA, LO=0xBB -> Done next cycle, DivZero=1, HI=0xAA, LO=0xBB unchanged.
REQ-033 Start pulsed mid-RUN is ignored (result matches first op); Reset at RUN cycle 10 -> no Done, HI=LO=0, next Start accepted normally.
